// File: rtl/prio_pkg.sv
// rtl/prio_pkg.sv - shared types, constants and map helper for the priority update block
package prio_pkg;

    localparam int PRIO_W      = 2;
    localparam int NUM_CLIENTS = 4;
    localparam int MAP_W       = PRIO_W * NUM_CLIENTS;

    // Client 1 highest (0) through client 4 lowest (3).
    localparam logic [MAP_W-1:0] DEFAULT_MAP = 8'b11_10_01_00;

    typedef logic [PRIO_W-1:0] prio_t;
    typedef logic [NUM_CLIENTS-1:0][PRIO_W-1:0] prio_vec_t;

    typedef enum logic {
        IDLE  = 1'b0,
        CHECK = 1'b1
    } state_t;

    // Split a packed map into per-client fields; element 0 is client 1.
    function automatic prio_vec_t unpack_map(input logic [MAP_W-1:0] map);
        prio_vec_t v;
        for (int i = 0; i < NUM_CLIENTS; i++) begin
            v[i] = map[i*PRIO_W +: PRIO_W];
        end
        return v;
    endfunction

endpackage

// File: rtl/prio_perm_check.sv
// rtl/prio_perm_check.sv - flags whether a packed 4x2-bit map is a permutation of 0..3
module prio_perm_check
    import prio_pkg::*;
(
    input  logic [MAP_W-1:0] map,
    output logic             is_perm
);

    prio_vec_t              fields;
    logic [NUM_CLIENTS-1:0] seen;

    assign fields = unpack_map(map);

    // Four fields covering all four values can only be a permutation.
    always_comb begin
        seen = '0;
        for (int i = 0; i < NUM_CLIENTS; i++) begin
            seen[fields[i]] = 1'b1;
        end
        is_perm = &seen;
    end

endmodule

// File: rtl/priority_update.sv
// rtl/priority_update.sv - LRG rotation plus checked software load of the priority map (option: PRIO_GRANT_ONLY_EN)
module priority_update
    import prio_pkg::*;
#(
    parameter logic [MAP_W-1:0] RESET_MAP = DEFAULT_MAP
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              grant_valid,
    input  logic [1:0]        grant_client,
    input  logic              cfg_valid,
    output logic              cfg_ready,
    input  logic [MAP_W-1:0]  cfg_map,
    output logic              cfg_error,
    output logic              grant_drop,
    output logic [PRIO_W-1:0] client_1_priority,
    output logic [PRIO_W-1:0] client_2_priority,
    output logic [PRIO_W-1:0] client_3_priority,
    output logic [PRIO_W-1:0] client_4_priority
);

    prio_vec_t prio_q;
    prio_vec_t rot_map;
    prio_t     grant_p;

    // Granted client sinks to 3; everyone that was below it moves up one.
    always_comb begin
        grant_p = prio_q[grant_client];
        rot_map = prio_q;
        for (int i = 0; i < NUM_CLIENTS; i++) begin
            if (2'(i) == grant_client) begin
                rot_map[i] = 2'd3;
            end else if (prio_q[i] > grant_p) begin
                rot_map[i] = prio_q[i] - 2'd1;
            end
        end
    end

`ifdef PRIO_GRANT_ONLY_EN

    logic unused_cfg;
    assign unused_cfg = ^{cfg_valid, cfg_map};

    assign cfg_ready  = 1'b0;
    assign cfg_error  = 1'b0;
    assign grant_drop = 1'b0;

    // Map changes only through rotation.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            prio_q <= unpack_map(RESET_MAP);
        end else if (grant_valid) begin
            prio_q <= rot_map;
        end
    end

`else

    state_t           state_q;
    state_t           state_d;
    logic [MAP_W-1:0] staged_q;
    logic             staged_perm;
    logic             cfg_error_q;
    logic             grant_drop_q;

    prio_perm_check u_perm_check (
        .map     (staged_q),
        .is_perm (staged_perm)
    );

    // Next state and handshake: one CHECK cycle after every accepted map.
    always_comb begin
        state_d   = state_q;
        cfg_ready = 1'b0;
        case (state_q)
            IDLE: begin
                cfg_ready = 1'b1;
                if (cfg_valid) begin
                    state_d = CHECK;
                end
            end
            CHECK: begin
                state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    // State register and staging capture on accept.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q  <= IDLE;
            staged_q <= '0;
        end else begin
            state_q <= state_d;
            if (cfg_valid && cfg_ready) begin
                staged_q <= cfg_map;
            end
        end
    end

    // Priority map, sticky error and drop pulse; CHECK applies or rejects the staged map.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            prio_q       <= unpack_map(RESET_MAP);
            cfg_error_q  <= 1'b0;
            grant_drop_q <= 1'b0;
        end else if (state_q == CHECK) begin
            grant_drop_q <= grant_valid;
            if (staged_perm) begin
                prio_q      <= unpack_map(staged_q);
                cfg_error_q <= 1'b0;
            end else begin
                cfg_error_q <= 1'b1;
            end
        end else begin
            grant_drop_q <= 1'b0;
            if (grant_valid) begin
                prio_q <= rot_map;
            end
        end
    end

    assign cfg_error  = cfg_error_q;
    assign grant_drop = grant_drop_q;

`endif

    assign client_1_priority = prio_q[0];
    assign client_2_priority = prio_q[1];
    assign client_3_priority = prio_q[2];
    assign client_4_priority = prio_q[3];

endmodule
